// File: rtl/avg_sched_pkg.sv
// Shared types and sizing helpers for the multi-channel moving-average scheduler.
package avg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Accumulator width that cannot overflow when summing win samples of data_w bits.
  function automatic int acc_width(input int data_w, input int win);
    return data_w + $clog2(win);
  endfunction

  // Right-shift that divides a window sum by the window length.
  function automatic int shift_amt(input int win);
    return $clog2(win);
  endfunction

endpackage

// File: rtl/avg_history_ram.sv
// Sample history store for all channels, addressed as {channel, pointer}.
// Synchronous read, no reset: fill counters decide whether contents are meaningful.
module avg_history_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port plus registered read port (read returns pre-write contents).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/multi_channel_average_scheduler.sv
// Round-robin scheduler sharing one moving-average datapath across NUM_CH channels.
// Each accepted sample walks IDLE -> READ -> UPDATE -> OUTPUT; result appears
// three cycles after the input handshake and is held until out_ready.
module multi_channel_average_scheduler
  import avg_sched_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int DATA_WIDTH  = 12,
  parameter  int WINDOW_SIZE = 16,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic                         cfg_clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_W-1:0]              out_ch,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  localparam int SHIFT  = shift_amt(WINDOW_SIZE);
  localparam int ACC_W  = acc_width(DATA_WIDTH, WINDOW_SIZE);
  localparam int PTR_W  = SHIFT;
  localparam int FILL_W = PTR_W + 1;
  localparam int ADDR_W = CH_W + PTR_W;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(WINDOW_SIZE);

  // Sign-extend a sample to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
    return {{SHIFT{v[DATA_WIDTH-1]}}, v};
  endfunction

  // Window sum divided by the window length (arithmetic shift, floor).
  function automatic logic signed [DATA_WIDTH-1:0] avg_of(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    t = a >>> SHIFT;
    return t[DATA_WIDTH-1:0];
  endfunction

  state_t                        state;
  logic [CH_W-1:0]               prio;
  logic [CH_W-1:0]               ch_p0;
  logic signed [DATA_WIDTH-1:0]  sample_p0;
  logic signed [ACC_W-1:0]       acc  [NUM_CH];
  logic [FILL_W-1:0]             fill [NUM_CH];
  logic [PTR_W-1:0]              wptr [NUM_CH];

  logic signed [DATA_WIDTH-1:0]  samp [NUM_CH];
  logic                          gnt_found;
  logic [CH_W-1:0]               gnt_ch;
  logic [CH_W-1:0]               next_prio;
  logic                          grant;
  logic [ADDR_W-1:0]             ram_addr;
  logic [DATA_WIDTH-1:0]         ram_rdata;
  logic signed [DATA_WIDTH-1:0]  oldest;
  logic signed [ACC_W-1:0]       acc_new;

  // Unpack the flat input bus into per-channel samples.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      samp[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search: first requester at or after the priority pointer.
  always_comb begin
    int unsigned     idx;
    logic [CH_W-1:0] idx_c;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    idx_c     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx   = (int'(prio) + i) % NUM_CH;
      idx_c = CH_W'(idx);
      if (!gnt_found && in_valid[idx_c]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx_c;
      end
    end
    next_prio = CH_W'((int'(gnt_ch) + 1) % NUM_CH);
  end

  // Accept strobe: only in IDLE, never during reset or a clear cycle.
  always_comb begin
    in_ready = '0;
    if (!rst && state == IDLE && !cfg_clear && gnt_found) begin
      in_ready[gnt_ch] = 1'b1;
    end
    grant = |(in_valid & in_ready);
  end

  // Oldest history entry counts as zero until the window has filled.
  always_comb begin
    ram_addr = {ch_p0, wptr[ch_p0]};
    oldest   = (fill[ch_p0] < FULL) ? '0 : $signed(ram_rdata);
    acc_new  = acc[ch_p0] + sext(sample_p0) - sext(oldest);
  end

  avg_history_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_CH * WINDOW_SIZE),
    .ADDR_W     (ADDR_W)
  ) u_hist (
    .clk   (clk),
    .we    (state == UPDATE),
    .waddr (ram_addr),
    .wdata (sample_p0),
    .raddr (ram_addr),
    .rdata (ram_rdata)
  );

  // Capture the granted sample for the shared datapath.
  always_ff @(posedge clk) begin
    if (grant) begin
      sample_p0 <= samp[gnt_ch];
    end
  end

  // Sequencing FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= '0;
      ch_p0     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            ch_p0 <= gnt_ch;
            prio  <= next_prio;
            state <= READ;
          end
        end
        READ: begin
          state <= UPDATE;
        end
        UPDATE: begin
          out_valid <= 1'b1;
          out_data  <= avg_of(acc_new);
          out_ch    <= ch_p0;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-channel window bookkeeping: clear in IDLE, update on the UPDATE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]  <= '0;
        fill[i] <= '0;
        wptr[i] <= '0;
      end
    end else if (state == IDLE && cfg_clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]  <= '0;
        fill[i] <= '0;
        wptr[i] <= '0;
      end
    end else if (state == UPDATE) begin
      acc[ch_p0]  <= acc_new;
      wptr[ch_p0] <= wptr[ch_p0] + 1'b1;
      if (fill[ch_p0] != FULL) begin
        fill[ch_p0] <= fill[ch_p0] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_average_scheduler.sv
// Directed bench for multi_channel_average_scheduler (NUM_CH=2, DATA_WIDTH=12, WINDOW_SIZE=16).
module tb_multi_channel_average_scheduler;

  logic               clk;
  logic               rst;
  logic [1:0]         in_valid;
  logic [23:0]        in_data;
  logic [1:0]         in_ready;
  logic               cfg_clear;
  logic               out_valid;
  logic               out_ready;
  logic [0:0]         out_ch;
  logic signed [11:0] out_data;

  int total = 0;
  int bad   = 0;

  multi_channel_average_scheduler #(
    .NUM_CH      (2),
    .DATA_WIDTH  (12),
    .WINDOW_SIZE (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_clear (cfg_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the result is visible.
  task automatic send(input int ch, input int val, output int och, output int odata, output int lat);
    int n;
    in_valid     = '0;
    in_valid[ch] = 1'b1;
    in_data[ch*12 +: 12] = 12'(val);
    n = 0;
    #1;
    while (!in_ready[ch] && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready", in_ready[ch], 1);
    @(negedge clk);
    in_valid = '0;
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    chk("valid", out_valid, 1);
    och   = int'(out_ch);
    odata = int'(out_data);
  endtask

  initial begin
    int och, od, lat, n, cyc, ir_bad, hold_cnt;
    int got_ch [6];
    int got_d  [6];
    int exp_ch [6] = '{0, 1, 0, 1, 0, 1};
    int exp_d  [6] = '{2, -2, 4, -4, 6, -6};

    rst = 1'b1; in_valid = 2'b11; in_data = '0; cfg_clear = 1'b0; out_ready = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = '0;
    @(negedge clk);

    // Constant 160 on ch0: ramp 10..160, then stays 160
    for (int k = 1; k <= 20; k++) begin
      send(0, 160, och, od, lat);
      chk("avg160", od, (k < 16 ? k : 16) * 10);
      chk("avg160_ch", och, 0);
      if (k == 1) chk("latency", lat, 3);
    end

    // Clear in IDLE blocks the grant, then window restarts
    @(negedge clk);
    cfg_clear = 1'b1; in_valid = 2'b01; in_data[11:0] = 12'd160;
    #1;
    chk("clear_in_ready", in_ready, 0);
    @(negedge clk);
    cfg_clear = 1'b0; in_valid = '0;
    send(0, 160, och, od, lat);
    chk("after_clear", od, 10);

    // Ch1 full-scale negative, then one zero
    for (int k = 1; k <= 16; k++) begin
      send(1, -2048, och, od, lat);
      chk("neg_ramp", od, -128 * k);
      chk("neg_ch", och, 1);
    end
    send(1, 0, och, od, lat);
    chk("neg_then_zero", od, -1920);

    // Fresh reset, then both channels request continuously
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    in_data[11:0] = 12'sd32; in_data[23:12] = -12'sd32; in_valid = 2'b11;
    n = 0; cyc = 0; ir_bad = 0;
    while (n < 6 && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
      if (out_valid && in_ready != 0) ir_bad++;
      if (out_valid) begin
        got_ch[n] = int'(out_ch);
        got_d[n]  = int'(out_data);
        n++;
        if (n == 6) in_valid = '0;
      end
    end
    chk("rr_count", n, 6);
    chk("rr_ready_outside_idle", ir_bad, 0);
    for (int i = 0; i < 6; i++) begin
      if (i < n) begin
        chk("rr_ch", got_ch[i], exp_ch[i]);
        chk("rr_data", got_d[i], exp_d[i]);
      end
    end

    // Backpressure: result held stable, no grants while waiting
    @(negedge clk);
    out_ready = 1'b0; in_valid = 2'b01; in_data[11:0] = 12'sd32;
    #1;
    chk("bp_grant", in_ready, 2'b01);
    @(negedge clk);
    in_valid = 2'b11;
    @(negedge clk);
    @(negedge clk); #1;
    chk("bp_valid_rise", out_valid, 1);
    hold_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_ch", out_ch, 0);
      chk("bp_data", out_data, 8);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = '0; out_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_release", out_valid, 0);

    // Reset during UPDATE discards the in-flight sample
    @(negedge clk);
    in_valid = 2'b01; in_data[11:0] = 12'sd64;
    #1;
    chk("rstu_grant", in_ready, 2'b01);
    @(negedge clk);
    in_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstu_out_valid", out_valid, 0);
    chk("rstu_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (out_valid) hold_cnt++;
    end
    chk("rstu_no_stale_out", hold_cnt, 0);
    send(0, 64, och, od, lat);
    chk("rstu_next_data", od, 4);
    chk("rstu_next_ch", och, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_average_scheduler.md
MULTI_CHANNEL_AVERAGE_SCHEDULER -- requirements
Module: multi_channel_average_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of requesting sample channels.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 12: signed sample width.
REQ-003 The block SHALL have parameter WINDOW_SIZE, default 16: moving-average window, a power of two of at least 2.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, NUM_CH: per-channel sample request.
REQ-007 The block SHALL have port in_data, input, NUM_CH x DATA_WIDTH signed: per-channel sample.
REQ-008 The block SHALL have port in_ready, output, NUM_CH: per-channel accept strobe.
REQ-009 The block SHALL have port cfg_clear, input, 1: clears all channel averaging state.
REQ-010 The block SHALL have port out_valid, output, 1: an averaged result is available.
REQ-011 The block SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 The block SHALL have port out_ch, output, $clog2(NUM_CH) (minimum 1): channel of the result.
REQ-013 The block SHALL have port out_data, output, DATA_WIDTH signed: averaged result.

Function
REQ-014 One moving-average datapath SHALL be time-shared by all channels; each channel SHALL have its own history of WINDOW_SIZE samples, accumulator and fill counter.
REQ-015 The FSM SHALL have states IDLE, READ, UPDATE and OUTPUT, with transitions IDLE->READ on a grant, READ->UPDATE unconditionally, UPDATE->OUTPUT unconditionally, and OUTPUT->IDLE on out_valid and out_ready.
REQ-016 In IDLE, a round-robin arbiter SHALL grant the first requesting channel at or after the priority pointer; in_ready SHALL be high only for that channel and only in that cycle, and the sample SHALL transfer when in_valid and in_ready are both high.
REQ-017 After each grant, the priority pointer SHALL become (granted channel + 1) mod NUM_CH.
REQ-018 In READ, the block SHALL fetch the channel's oldest history entry; if the fill counter is below WINDOW_SIZE, the oldest value SHALL be treated as 0.
REQ-019 In UPDATE, the block SHALL compute acc_new = acc + sample - oldest, store acc_new, write the sample at the channel's write pointer, advance the write pointer mod WINDOW_SIZE, and increment the fill counter, saturating at WINDOW_SIZE.
REQ-020 The accumulator SHALL be signed with width DATA_WIDTH + $clog2(WINDOW_SIZE), so it never overflows.
REQ-021 out_data SHALL equal acc_new arithmetically shifted right by $clog2(WINDOW_SIZE).
REQ-022 out_valid SHALL rise in the cycle after UPDATE, so the result is valid 3 cycles after the handshake.
REQ-023 out_valid, out_data and out_ch SHALL hold stable while out_ready is low; no grant SHALL occur until the result is accepted, and all in_ready bits SHALL be 0 outside IDLE.
REQ-024 cfg_clear SHALL be acted on only in IDLE, where it SHALL zero every accumulator, fill counter and write pointer and take priority over a grant (all in_ready 0 that cycle); outside IDLE it SHALL be ignored.
REQ-025 With NUM_CH = 1, the arbiter SHALL degenerate to always granting channel 0.

Reset
REQ-026 rst SHALL asynchronously force: state IDLE, priority pointer 0, all accumulators, fill counters and write pointers 0, out_valid 0, out_data 0, out_ch 0, and in_ready all 0.
REQ-027 History storage SHALL NOT be reset; the fill counters make its contents irrelevant.
REQ-028 A reset mid-operation SHALL discard the in-flight sample, and the next accepted sample per channel SHALL restart its window from empty.

Structure
REQ-029 Package avg_sched_pkg SHALL hold the FSM state enum and functions returning the accumulator width and shift amount.
REQ-030 History storage SHALL be a sub-module avg_history_ram: a synchronous-read RAM of depth NUM_CH*WINDOW_SIZE, addressed as {channel, pointer}, with no reset.

Verification (NUM_CH=2, DATA_WIDTH=12, WINDOW_SIZE=16)
REQ-031 Ch0 sends 160 repeatedly: the outputs SHALL be 10, 20, ..., and reach 160 at the 16th sample and remain 160.
REQ-032 Both channels hold in_valid high continuously: grants and out_ch SHALL alternate 0,1,0,1, starting at 0.
REQ-033 out_ready is held low for 5 cycles in OUTPUT: out_valid, out_ch and out_data SHALL stay stable and in_ready SHALL stay 0.
REQ-034 Ch1 receives 16 samples of -2048, then one sample of 0: the outputs SHALL be -2048, then -1920.
REQ-035 rst is asserted during UPDATE, then ch0 sends 64: out_valid SHALL drop immediately, and the next output SHALL be ch0 = 4.
REQ-036 cfg_clear is pulsed in IDLE after 16 samples of 160 on ch0, then ch0 sends 160: the output SHALL be 10, and no in_ready SHALL be asserted in the clear cycle.
